hub75_row_shifter: RTL and testbench

- Parametrised successor to the single-panel HUB75 colour transmitter. On each accepted start, it shifts one bit-plane of one row out to a chain of panels.
- It supports any number of segments, chained panels, and pipelined frame-memory read latency. It also has a programmable latch pulse, an output-blank signal, abort, and a done pulse.
- It sits between the frame buffer and the panel pins, under control of the row/bit-plane scheduler.

---
 rtl/hub75_row_shifter.sv | 206 ++++++++++++++++++++
 tb/tb_hub75_row_shifter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_row_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_row_shifter: shifts one bit-plane of one row out to a HUB75 chain.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module hub75_row_shifter #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  parameter int chain_p    = 1,
  parameter int rd_lat_p   = 1,
  localparam int L  = hpixel_p * chain_p,
  localparam int AW = $clog2(L * vpixel_p / segments_p),
  localparam int PW = (bpp_p > 1) ? $clog2(bpp_p) : 1,
  localparam int CW = $clog2(L),
  localparam int DW = segments_p * 3 * bpp_p
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_clk_div,
  input  logic [3:0]            i_latch_len,
  input  logic                  i_tx_start,
  input  logic                  i_abort,
  input  logic [AW-1:0]         i_init_addr,
  input  logic [PW-1:0]         i_pix_bit,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [AW-1:0]         o_rd_addr,
  input  logic [DW-1:0]         i_rd_data,
  output logic                  o_serial_clk,
  output logic [segments_p-1:0] o_red,
  output logic [segments_p-1:0] o_green,
  output logic [segments_p-1:0] o_blue,
  output logic                  o_latch_en,
  output logic                  o_blank
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0]  RD_LAT   = 4'(rd_lat_p);
  localparam logic [3:0]  PRE_LAST = 4'(rd_lat_p - 1);
  localparam logic [CW:0] PIX_LAST = (CW+1)'(L - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            lo_q, lo_d, hi_q, hi_d, lat_q, lat_d;
  logic [CW:0]           pix_q, pix_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PW-1:0]         bit_q, bit_d;
  logic [segments_p-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [segments_p-1:0] w_red, w_grn, w_blu;
  logic [3:0]            w_div, w_lo, w_hi_raw, w_hi, w_lat;

  // High phase is stretched so the prefetched pixel is valid by the next low phase.
  always_comb begin
    w_div    = (i_clk_div < 4'd2) ? 4'd2 : i_clk_div;
    w_lo     = w_div >> 1;
    w_hi_raw = w_div - w_lo;
    w_hi     = (w_hi_raw < RD_LAT) ? RD_LAT : w_hi_raw;
    w_lat    = (i_latch_len == 4'd0) ? 4'd1 : i_latch_len;
  end

  generate
    for (genvar s = 0; s < segments_p; s++) begin : g_seg
      logic [bpp_p-1:0] w_rw, w_gw, w_bw;
      assign w_rw     = i_rd_data[(s*3+2)*bpp_p +: bpp_p];
      assign w_gw     = i_rd_data[(s*3+1)*bpp_p +: bpp_p];
      assign w_bw     = i_rd_data[(s*3+0)*bpp_p +: bpp_p];
      assign w_red[s] = w_rw[bit_q];
      assign w_grn[s] = w_gw[bit_q];
      assign w_blu[s] = w_bw[bit_q];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    lat_d   = lat_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    red_d   = red_q;
    grn_d   = grn_q;
    blu_d   = blu_q;
    case (state_q)
      S_IDLE: begin
        if (i_tx_start) begin
          state_d = S_PRE;
          cnt_d   = 4'd0;
          pix_d   = '0;
          addr_d  = i_init_addr;
          lo_d    = w_lo;
          hi_d    = w_hi;
          lat_d   = w_lat;
          bit_d   = i_pix_bit;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOW: begin
        if (cnt_q == 4'd0) begin
          red_d = w_red;
          grn_d = w_grn;
          blu_d = w_blu;
        end
        // Address advances as HIGH is entered so it is visible on HIGH's first cycle.
        if (cnt_q == lo_q - 4'd1) begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
          addr_d  = addr_q + AW'(1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == hi_q - 4'd1) begin
          cnt_d = 4'd0;
          if (pix_q == PIX_LAST) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_LOW;
            pix_d   = pix_q + (CW+1)'(1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == lat_q - 4'd1) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
          red_d   = '0;
          grn_d   = '0;
          blu_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      red_d   = '0;
      grn_d   = '0;
      blu_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      lat_q   <= 4'd0;
      pix_q   <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      lat_q   <= lat_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_serial_clk = (state_q == S_HIGH);
  assign o_latch_en   = (state_q == S_LATCH);
  assign o_blank      = (state_q == S_LATCH);
  assign o_rd_addr    = addr_q;
  assign o_red        = red_q;
  assign o_green      = grn_q;
  assign o_blue       = blu_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_row_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hub75_row_shifter: scoreboard bench for hub75_row_shifter.                |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_hub75_row_shifter;

  localparam int HP  = 16;
  localparam int VP  = 4;
  localparam int BPP = 8;
  localparam int SEG = 2;
  localparam int CH  = 2;
  localparam int RDL = 2;
  localparam int L   = HP * CH;
  localparam int AW  = $clog2(L * VP / SEG);
  localparam int PW  = $clog2(BPP);
  localparam int DW  = SEG * 3 * BPP;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     i_clk_div, i_latch_len;
  logic           i_tx_start, i_abort;
  logic [AW-1:0]  i_init_addr;
  logic [PW-1:0]  i_pix_bit;
  logic           o_ready, o_done, o_serial_clk, o_latch_en, o_blank;
  logic [AW-1:0]  o_rd_addr;
  logic [DW-1:0]  i_rd_data;
  logic [SEG-1:0] o_red, o_green, o_blue;

  always #5 clk = ~clk;

  hub75_row_shifter #(
    .hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP),
    .segments_p(SEG), .chain_p(CH), .rd_lat_p(RDL)
  ) dut (
    .clk(clk), .rst(rst), .i_clk_div(i_clk_div), .i_latch_len(i_latch_len),
    .i_tx_start(i_tx_start), .i_abort(i_abort), .i_init_addr(i_init_addr),
    .i_pix_bit(i_pix_bit), .o_ready(o_ready), .o_done(o_done),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_serial_clk(o_serial_clk),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_latch_en(o_latch_en), .o_blank(o_blank)
  );

  function automatic logic [BPP-1:0] memword(input logic [AW-1:0] a, input int s, input int c);
    int v;
    v = int'(a) * 37 + s * 101 + c * 59 + 13;
    return v[BPP-1:0];
  endfunction

  function automatic logic [DW-1:0] mem_bus(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int s = 0; s < SEG; s++)
      for (int c = 0; c < 3; c++)
        r[(s*3+c)*BPP +: BPP] = memword(a, s, c);
    return r;
  endfunction

  function automatic logic [3*SEG-1:0] exp_pix(input logic [AW-1:0] a, input int b);
    logic [SEG-1:0] r, g, bl;
    logic [BPP-1:0] w;
    for (int s = 0; s < SEG; s++) begin
      w = memword(a, s, 2); r[s]  = w[b];
      w = memword(a, s, 1); g[s]  = w[b];
      w = memword(a, s, 0); bl[s] = w[b];
    end
    return {r, g, bl};
  endfunction

  // Frame memory with RDL cycles of read latency.
  logic [AW-1:0] apipe [RDL];
  always @(posedge clk) begin
    apipe[0] <= o_rd_addr;
    for (int k = 1; k < RDL; k++) apipe[k] <= apipe[k-1];
  end
  assign i_rd_data = mem_bus(apipe[RDL-1]);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    int lo;
    int hi;
    int lat;
    int cycles;
    bit done;
  } cfg_t;

  cfg_t             cfg_q[$];
  logic [3*SEG-1:0] pix_q[$];

  // Monitor: pairs every serial clock rise and every done pulse with queued expectations.
  cfg_t cur;
  int   ncyc = 0, n0 = 0, rises = 0, hcnt = 0, lcnt = 0, lat_cnt = 0;
  bit   active = 1'b0, quiet = 1'b0, prev_s = 1'b0;
  initial begin
    logic [3*SEG-1:0] e_pix;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst || (i_abort && !o_ready)) quiet = 1'b1;
      check("blank_vs_latch", int'(o_blank), int'(o_latch_en));
      if (o_serial_clk && !prev_s) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL extra_sclk: got serial clock rise %0d with no pixel expected", rises + 1);
        end else begin
          e_pix = pix_q.pop_front();
          checks--;
          check("pixel_bits", int'({o_red, o_green, o_blue}), int'(e_pix));
        end
        if (rises > 0 && !quiet) check("lo_len", lcnt, cur.lo);
        rises++;
        hcnt = 0;
      end
      if (!o_serial_clk && prev_s) begin
        if (!quiet) check("hi_len", hcnt, cur.hi);
        lcnt = 0;
      end
      if (o_serial_clk) hcnt++;
      else lcnt++;
      if (o_latch_en) lat_cnt++;
      if (o_done) begin
        checks++;
        if (!active || !cur.done) begin
          errors++;
          $display("FAIL unexpected_done: got o_done=1 expected 0 (t=%0t)", $time);
        end else begin
          checks--;
          check("done_cycles", ncyc - n0, cur.cycles);
          check("latch_len", lat_cnt, cur.lat);
          check("sclk_count", rises, L);
          check("colour_clear", int'({o_red, o_green, o_blue}), 0);
        end
        active = 1'b0;
      end
      if (o_ready && i_tx_start && !rst) begin
        checks++;
        if (cfg_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_accept: got accept expected none (t=%0t)", $time);
        end else begin
          checks--;
          cur     = cfg_q.pop_front();
          n0      = ncyc;
          rises   = 0;
          lat_cnt = 0;
          quiet   = 1'b0;
          active  = 1'b1;
        end
      end
      prev_s = o_serial_clk;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Queue expectations, issue one start, scramble config, poke a busy start.
  task automatic run(input int div, input int len, input int bitp, input int addr,
                     input int lo, input int hi, input int lat, input int npix,
                     input bit done, input bit ab);
    cfg_t c;
    int   k;
    c = '{lo, hi, lat, 1 + RDL + L * (lo + hi) + lat, done};
    cfg_q.push_back(c);
    for (int p = 0; p < npix; p++) pix_q.push_back(exp_pix(AW'(addr + p), bitp));
    k = 0;
    while (!o_ready && k < 500) begin tick; k++; end
    check("ready_before_start", int'(o_ready), 1);
    i_clk_div   = 4'(div);
    i_latch_len = 4'(len);
    i_pix_bit   = PW'(bitp);
    i_init_addr = AW'(addr);
    i_abort     = ab;
    i_tx_start  = 1'b1;
    tick;
    i_tx_start  = 1'b0;
    i_abort     = 1'b0;
    i_clk_div   = 4'hF;
    i_latch_len = 4'h9;
    i_pix_bit   = ~i_pix_bit;
    i_init_addr = ~i_init_addr;
    repeat (4) tick;
    i_tx_start = 1'b1;
    tick;
    i_tx_start = 1'b0;
    if (done) begin
      k = 0;
      while (!o_done && k < c.cycles + 50) begin tick; k++; end
      check("done_seen", int'(o_done), 1);
      tick;
    end
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_sclk"}, int'(o_serial_clk), 0);
    check({tag, "_latch"}, int'(o_latch_en), 0);
    check({tag, "_blank"}, int'(o_blank), 0);
    check({tag, "_colour"}, int'({o_red, o_green, o_blue}), 0);
    check({tag, "_ready"}, int'(o_ready), 1);
    check({tag, "_done"}, int'(o_done), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    i_clk_div = '0; i_latch_len = '0; i_tx_start = 1'b0; i_abort = 1'b0;
    i_init_addr = '0; i_pix_bit = '0;
    repeat (3) tick;
    check_idle_pins("reset");
    check("reset_addr", int'(o_rd_addr), 0);
    rst = 1'b0;
    tick;

    run(4, 1, 3, 0,  2, 2, 1, L, 1'b1, 1'b0);
    run(2, 3, 0, 5,  1, 2, 3, L, 1'b1, 1'b0);
    run(0, 0, 7, 50, 1, 2, 1, L, 1'b1, 1'b0);
    run(7, 2, 5, 63, 3, 4, 2, L, 1'b1, 1'b0);

    // Abort after ten serial clocks.
    run(3, 1, 2, 20, 1, 2, 1, 10, 1'b0, 1'b0);
    k = 0;
    while (rises < 10 && k < 500) begin tick; k++; end
    check("abort_reached", int'(rises >= 10), 1);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    check_idle_pins("abort");
    for (int j = 0; j < 6; j++) begin
      tick;
      check("abort_no_latch", int'(o_latch_en | o_done), 0);
    end
    run(5, 1, 6, 40, 2, 3, 1, L, 1'b1, 1'b1);

    // Asynchronous reset while the serial clock is high.
    run(4, 1, 4, 33, 2, 2, 1, 5, 1'b0, 1'b0);
    k = 0;
    while (!(rises >= 5 && o_serial_clk) && k < 500) begin tick; k++; end
    check("reset_point_reached", int'(o_serial_clk), 1);
    #2 rst = 1'b1;
    #1 check_idle_pins("async_rst");
    check("async_rst_addr", int'(o_rd_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick;
    check("post_rst_ready", int'(o_ready), 1);

    run(2, 15, 1, 10, 1, 2, 15, L, 1'b1, 1'b0);
    repeat (5) tick;
    check("queues_drained", pix_q.size() + cfg_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
